axis_pkt_arbiter: RTL
=====================

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Parameters
REQ-001 NUM_REQ, default 4: number of AXI-Stream slave channels; legal range 2..16.
REQ-002 DATA_WIDTH, default 64: tdata width of every channel.
REQ-003 CNT_WIDTH, default 32: width of the delivered-packet counter.

Interface
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 arb_enable  in  1  0 = serve only channel 0; 1 = normal arbitration.
REQ-007 arb_mode  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-008 s_axis_tvalid  in  NUM_REQ  per-channel valid.
REQ-009 s_axis_tready  out  NUM_REQ  per-channel ready.
REQ-010 s_axis_tdata  in  NUM_REQ*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 s_axis_tlast  in  NUM_REQ  per-channel end of packet.
REQ-012 m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast  out/in/out/out  1/1/DATA_WIDTH/1  merged master stream.
REQ-013 grant  out  NUM_REQ  registered one-hot owner; all zero when no owner.
REQ-014 busy  out  1  high while a packet is locked.
REQ-015 pkt_cnt  out  CNT_WIDTH  packets delivered on the master port since reset.

Function
REQ-016 The FSM SHALL have two states: IDLE and LOCK.
REQ-017 IDLE: when any s_axis_tvalid bit permitted by REQ-018 is high, the block SHALL load grant with the winner and move to LOCK at the same edge; otherwise it stays in IDLE.
REQ-018 arb_enable=0: only channel 0 is eligible; the winner is channel 0 if s_axis_tvalid[0]=1, otherwise there is no winner.
REQ-019 arb_enable=1, arb_mode=0: the winner is the lowest-index valid channel.
REQ-020 arb_enable=1, arb_mode=1: the winner is the first valid channel at or above the one-hot rr_ptr, wrapping from NUM_REQ-1 to 0 (double-width request minus base method).
REQ-021 arb_enable and arb_mode SHALL be sampled only in IDLE; changes during LOCK take effect at the next arbitration.
REQ-022 LOCK, data path: m_axis_tvalid/tdata/tlast = the granted channel's signals; s_axis_tready[g] = m_axis_tready; all other tready bits = 0 (combinational mux).
REQ-023 IDLE outputs: m_axis_tvalid=0, s_axis_tready=0.
REQ-024 Latency: the first beat can be accepted no earlier than 1 cycle after tvalid rises.
REQ-025 The grant SHALL hold for the whole packet, ignoring all other requests, including a granted tvalid that drops mid-packet.
REQ-026 On a handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast) in LOCK:
  - return to IDLE and clear grant;
  - increment pkt_cnt, wrapping modulo 2^CNT_WIDTH;
  - if arb_mode=1, load rr_ptr with grant rotated left by 1 (NUM_REQ-1 wraps to 0).
  Exactly one idle bubble cycle therefore separates packets.
REQ-027 In fixed mode rr_ptr SHALL NOT change.
REQ-028 A single-beat packet (tlast on the first beat) SHALL complete in one LOCK cycle.
REQ-029 busy SHALL equal (state==LOCK).
REQ-030 rr_ptr SHALL always be one-hot.

Reset
REQ-031 While rst=1 at a clock edge, the following SHALL take effect, overriding any handshake in flight:
  - state=IDLE;
  - grant=0, busy=0, pkt_cnt=0;
  - rr_ptr=channel 0.
REQ-032 During reset, combinational outputs SHALL follow the IDLE rules: m_axis_tvalid=0, s_axis_tready=0.
REQ-033 A packet interrupted by reset SHALL be abandoned and not counted; after reset, arbitration restarts from channel 0.

Verification (NUM_REQ=4, DATA_WIDTH=64)
REQ-034 Fixed mode: tvalid=4'b1010, 2-beat packets, m_tready=1 -> ch1 is served first (grant=0010), ch3 after a 1-cycle bubble, pkt_cnt=2.
REQ-035 Round-robin: all 4 channels valid with continuous 1-beat packets -> grant sequence 0001,0010,0100,1000,0001; one bubble between grants.
REQ-036 Lock hold: ch2 granted, m_tready toggling 1/0, ch0 asserts tvalid mid-packet -> grant stays 0100 until ch2's tlast handshake; all data beats arrive in order.
REQ-037 arb_enable=0 with tvalid=4'b0110 -> grant stays 0, busy=0; then tvalid[0]=1 -> grant=0001 on the next edge.
REQ-038 Reset mid-packet (ch3 locked, beat 2 of 4) -> next cycle: grant=0, pkt_cnt unchanged at 0; with all channels valid, round-robin grants ch0 first.
REQ-039 Counter wrap with CNT_WIDTH=4: 17 packets -> pkt_cnt=1.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Packet-level AXI-Stream arbiter: merges NUM_REQ slave streams onto one master port.
// A grant is held for a whole packet. Fixed-priority or round-robin selection is chosen per packet.
module axis_pkt_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_enable,
  input  logic                          arb_mode,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_cnt
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state;
  logic [NUM_REQ-1:0]       rr_ptr;
  logic                     lock_mode;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       fixed_win;
  logic [NUM_REQ-1:0]       rr_win;
  logic [NUM_REQ-1:0]       winner;
  logic [2*NUM_REQ-1:0]     req_dbl;
  logic [2*NUM_REQ-1:0]     rr_dbl;
  logic                     pkt_done;

  assign req       = arb_enable ? s_axis_tvalid : {{(NUM_REQ-1){1'b0}}, s_axis_tvalid[0]};
  assign fixed_win = req & (~req + NUM_REQ'(1));

  // Subtracting the pointer from the doubled request vector isolates the first
  // request at or above rr_ptr, with the upper copy covering the wrap-around.
  assign req_dbl = {req, req};
  assign rr_dbl  = req_dbl & ~(req_dbl - {{NUM_REQ{1'b0}}, rr_ptr});
  assign rr_win  = rr_dbl[NUM_REQ-1:0] | rr_dbl[2*NUM_REQ-1:NUM_REQ];
  assign winner  = (arb_enable && arb_mode) ? rr_win : fixed_win;

  assign busy = (state == LOCK);

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) m_axis_tdata = m_axis_tdata | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reset gates the handshake so a packet in flight is dropped, not completed.
  assign m_axis_tvalid = busy && !rst && (|(s_axis_tvalid & grant));
  assign m_axis_tlast  = |(s_axis_tlast & grant);
  assign s_axis_tready = (busy && !rst && m_axis_tready) ? grant : '0;
  assign pkt_done      = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= NUM_REQ'(1);
      pkt_cnt   <= '0;
      lock_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|winner) begin
            grant     <= winner;
            lock_mode <= arb_mode;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (pkt_done) begin
            state   <= IDLE;
            grant   <= '0;
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            if (lock_mode) rr_ptr <= {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
